// File: rtl/levinson_seq_if.sv
// Bus bundle for the Levinson-Durbin sequencer: control, ping-pong RAM ports, multiplier and datapath.
// LEVINSON_CYCCNT_EN adds the last_cycles measurement output.
interface levinson_seq_if #(parameter int AW = 4);
  logic          start;
  logic [AW-1:0] order;
  logic [31:0]   k;
  logic          busy;
  logic          done;
  logic          err;
  logic          cur_bank;
  logic [AW-1:0] rd_addr_a;
  logic [AW-1:0] rd_addr_b;
  logic          rd_bank;
  logic [31:0]   rd_data_a;
  logic [31:0]   rd_data_b;
  logic          mul_en;
  logic [31:0]   mul_x;
  logic [31:0]   mul_y;
  logic [31:0]   temp;
  logic [31:0]   dp_a;
  logic [31:0]   dp_k;
  logic          out_sel;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic          wr_bank;
`ifdef LEVINSON_CYCCNT_EN
  logic [15:0]   last_cycles;
`endif

  modport master (
`ifdef LEVINSON_CYCCNT_EN
    input  last_cycles,
`endif
    output start, order, k, rd_data_a, rd_data_b, temp,
    input  busy, done, err, cur_bank, rd_addr_a, rd_addr_b, rd_bank,
    input  mul_en, mul_x, mul_y, dp_a, dp_k, out_sel, wr_en, wr_addr, wr_bank
  );

  modport slave (
`ifdef LEVINSON_CYCCNT_EN
    output last_cycles,
`endif
    input  start, order, k, rd_data_a, rd_data_b, temp,
    output busy, done, err, cur_bank, rd_addr_a, rd_addr_b, rd_bank,
    output mul_en, mul_x, mul_y, dp_a, dp_k, out_sel, wr_en, wr_addr, wr_bank
  );
endinterface

// File: rtl/levinson_seq.sv
// Levinson-Durbin coefficient-update sequencer over a ping-pong RAM and a pipelined multiplier.
// Define LEVINSON_CYCCNT_EN to add the last_cycles run-length counter.
module levinson_seq #(
  parameter int ORDER   = 10,
  parameter int AW      = 4,
  parameter int MUL_LAT = 2
) (
  input  logic          clk,
  input  logic          rst,
  levinson_seq_if.slave bus
);
  typedef enum logic [2:0] {S_IDLE, S_STREAM, S_DRAIN, S_WRITE_K, S_DONE} state_t;

  localparam logic [AW-1:0] ORD_MAX = AW'(ORDER);

  state_t              r_state;
  logic [AW-1:0]       r_ord;
  logic [AW-1:0]       r_j;
  logic [31:0]         r_k;
  logic                r_busy;
  logic                r_done;
  logic                r_err;
  logic                r_cur_bank;
  logic [AW-1:0]       r_rd_addr_a;
  logic [AW-1:0]       r_rd_addr_b;
  logic                r_wr_en;
  logic                r_out_sel;
  logic [AW-1:0]       r_wr_addr;
  logic [31:0]         r_dp_a;
  // Stage 0 is the multiplier issue cycle; stage MUL_LAT-1 feeds the write registers.
  logic [MUL_LAT-1:0]  r_pv;
  logic [AW-1:0]       r_pa [MUL_LAT];
  logic [31:0]         w_tail_a;
  logic                w_order_ok;

  assign w_order_ok = (bus.order != '0) && (bus.order <= ORD_MAX);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pv <= '0;
      for (int s = 0; s < MUL_LAT; s++) r_pa[s] <= '0;
    end else begin
      r_pv[0] <= (r_state == S_STREAM);
      r_pa[0] <= r_rd_addr_a;
      for (int s = 1; s < MUL_LAT; s++) begin
        r_pv[s] <= r_pv[s-1];
        r_pa[s] <= r_pa[s-1];
      end
    end
  end

  if (MUL_LAT == 1) begin : g_lat1
    assign w_tail_a = bus.rd_data_a;
  end else begin : g_latn
    logic [31:0] r_pd [1:MUL_LAT-1];
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        for (int s = 1; s < MUL_LAT; s++) r_pd[s] <= '0;
      end else begin
        r_pd[1] <= bus.rd_data_a;
        for (int s = 2; s < MUL_LAT; s++) r_pd[s] <= r_pd[s-1];
      end
    end
    assign w_tail_a = r_pd[MUL_LAT-1];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_ord       <= '0;
      r_j         <= '0;
      r_k         <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
      r_cur_bank  <= 1'b0;
      r_rd_addr_a <= '0;
      r_rd_addr_b <= '0;
      r_wr_en     <= 1'b0;
      r_out_sel   <= 1'b0;
      r_wr_addr   <= '0;
      r_dp_a      <= '0;
    end else begin
      r_done    <= 1'b0;
      r_err     <= 1'b0;
      r_wr_en   <= r_pv[MUL_LAT-1];
      r_out_sel <= r_pv[MUL_LAT-1];
      if (r_pv[MUL_LAT-1]) begin
        r_wr_addr <= r_pa[MUL_LAT-1];
        r_dp_a    <= w_tail_a;
      end
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            if (w_order_ok) begin
              r_ord  <= bus.order;
              r_k    <= bus.k;
              r_busy <= 1'b1;
              if (bus.order > AW'(1)) begin
                r_state     <= S_STREAM;
                r_j         <= AW'(1);
                r_rd_addr_a <= AW'(1);
                r_rd_addr_b <= bus.order - AW'(1);
              end else begin
                r_state   <= S_WRITE_K;
                r_wr_en   <= 1'b1;
                r_out_sel <= 1'b0;
                r_wr_addr <= bus.order;
              end
            end else begin
              r_err <= 1'b1;
            end
          end
        end
        S_STREAM: begin
          if (r_j == r_ord - AW'(1)) begin
            r_state <= S_DRAIN;
          end else begin
            r_j         <= r_j + AW'(1);
            r_rd_addr_a <= r_j + AW'(1);
            r_rd_addr_b <= r_ord - r_j - AW'(1);
          end
        end
        S_DRAIN: begin
          // Empty stages mean the final update write is already in the output register.
          if (r_pv == '0) begin
            r_state   <= S_WRITE_K;
            r_wr_en   <= 1'b1;
            r_out_sel <= 1'b0;
            r_wr_addr <= r_ord;
          end
        end
        S_WRITE_K: begin
          r_state    <= S_DONE;
          r_done     <= 1'b1;
          r_busy     <= 1'b0;
          r_cur_bank <= ~r_cur_bank;
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

`ifdef LEVINSON_CYCCNT_EN
  logic [15:0] r_cnt;
  logic [15:0] r_last;
  // r_cnt covers the start cycle up to the one before WRITE_K; +2 adds WRITE_K and DONE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt  <= '0;
      r_last <= '0;
    end else if (r_state == S_IDLE) begin
      if (bus.start && w_order_ok) r_cnt <= 16'd1;
    end else if (r_state == S_WRITE_K) begin
      r_last <= (r_cnt >= 16'hFFFD) ? 16'hFFFF : r_cnt + 16'd2;
    end else if (r_cnt != 16'hFFFF) begin
      r_cnt <= r_cnt + 16'd1;
    end
  end
  assign bus.last_cycles = r_last;
`endif

  assign bus.busy      = r_busy;
  assign bus.done      = r_done;
  assign bus.err       = r_err;
  assign bus.cur_bank  = r_cur_bank;
  assign bus.rd_bank   = r_cur_bank;
  assign bus.wr_bank   = ~r_cur_bank;
  assign bus.rd_addr_a = r_rd_addr_a;
  assign bus.rd_addr_b = r_rd_addr_b;
  assign bus.mul_en    = r_pv[0];
  assign bus.mul_x     = r_k;
  assign bus.mul_y     = bus.rd_data_b;
  assign bus.dp_a      = r_dp_a;
  assign bus.dp_k      = r_k;
  assign bus.out_sel   = r_out_sel;
  assign bus.wr_en     = r_wr_en;
  assign bus.wr_addr   = r_wr_addr;
endmodule

// File: tb/tb_levinson_seq.sv
// Scoreboard bench for levinson_seq: RAM/multiplier/datapath environment plus an arithmetic
// reference of the coefficient recursion; expected events are queued at start and checked by a monitor.
module tb_levinson_seq;
  localparam int ORDER   = 10;
  localparam int AW      = 4;
  localparam int MUL_LAT = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  levinson_seq_if #(.AW(AW)) bus();
  levinson_seq #(.ORDER(ORDER), .AW(AW), .MUL_LAT(MUL_LAT)) dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct { int cyc; logic [AW-1:0] addr; logic bank; logic sel; logic [31:0] data; } wr_t;
  typedef struct { int cyc; logic bank; logic [31:0] x; logic [31:0] y; } mul_t;
  typedef struct { int cyc; logic is_err; logic bank; } ev_t;

  wr_t  q_wr[$];
  mul_t q_mul[$];
  ev_t  q_ev[$];

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  logic [31:0] init_words [2][16];
  logic [31:0] ram        [2][16];
  logic [31:0] ref_bank   [2][16];
  logic        ref_cur;
  logic        ram_load = 1'b1;
  logic [31:0] mpipe [MUL_LAT];
  logic [31:0] next_a;

  // Q4.28 multiply with round-half-up, as the external multiplier does.
  function automatic logic [31:0] qmul(input logic [31:0] x, input logic [31:0] y);
    longint p;
    p = longint'($signed(x)) * longint'($signed(y));
    p = p + 64'sd134217728;
    return 32'(p >>> 28);
  endfunction

  function automatic logic [31:0] small_rand();
    logic [31:0] r;
    r = $urandom;
    return {{4{r[27]}}, r[27:0]};
  endfunction

  task automatic chk(input string name, input bit ok, input string detail);
    n_checks++;
    if (ok) n_pass++;
    else $display("FAIL %s: %s", name, detail);
  endtask

  assign next_a   = bus.out_sel ? bus.dp_a + bus.temp : bus.dp_k;
  assign bus.temp = mpipe[MUL_LAT-1];

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    if (ram_load) begin
      for (int b = 0; b < 2; b++)
        for (int a = 0; a < 16; a++) ram[b][a] <= init_words[b][a];
    end else if (bus.wr_en) begin
      ram[bus.wr_bank][bus.wr_addr] <= next_a;
    end
    bus.rd_data_a <= ram[bus.rd_bank][bus.rd_addr_a];
    bus.rd_data_b <= ram[bus.rd_bank][bus.rd_addr_b];
    mpipe[0] <= bus.mul_en ? qmul(bus.mul_x, bus.mul_y) : 32'hDEAD_BEEF;
    for (int s = 1; s < MUL_LAT; s++) mpipe[s] <= mpipe[s-1];
  end

  // Monitor: every DUT event pops its queue; an empty queue yields cycle -1 and thus a mismatch.
  initial begin
    wr_t w; mul_t m; ev_t e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (bus.mul_en) begin
          if (q_mul.size() == 0) begin m.cyc = -1; m.bank = 0; m.x = 0; m.y = 0; end
          else m = q_mul.pop_front();
          chk("mul", m.cyc == cyc && bus.mul_x == m.x && bus.mul_y == m.y && bus.rd_bank == m.bank,
              $sformatf("cyc %0d x=%h y=%h bank=%0d, required cyc %0d x=%h y=%h bank=%0d",
                        cyc, bus.mul_x, bus.mul_y, bus.rd_bank, m.cyc, m.x, m.y, m.bank));
        end
        if (bus.wr_en) begin
          if (q_wr.size() == 0) begin w.cyc = -1; w.addr = 0; w.bank = 0; w.sel = 0; w.data = 0; end
          else w = q_wr.pop_front();
          chk("write", w.cyc == cyc && bus.wr_addr == w.addr && bus.wr_bank == w.bank &&
                       bus.out_sel == w.sel && next_a == w.data && bus.wr_bank != bus.rd_bank,
              $sformatf("cyc %0d addr=%0d bank=%0d sel=%0d data=%h rd_bank=%0d, required cyc %0d addr=%0d bank=%0d sel=%0d data=%h",
                        cyc, bus.wr_addr, bus.wr_bank, bus.out_sel, next_a, bus.rd_bank,
                        w.cyc, w.addr, w.bank, w.sel, w.data));
        end
        if (bus.done || bus.err) begin
          if (q_ev.size() == 0) begin e.cyc = -1; e.is_err = 0; e.bank = 0; end
          else e = q_ev.pop_front();
          chk(e.is_err ? "err" : "done",
              e.cyc == cyc && bus.err == e.is_err && bus.done == !e.is_err &&
              (e.is_err || bus.cur_bank == e.bank),
              $sformatf("cyc %0d done=%0d err=%0d cur_bank=%0d, required cyc %0d err=%0d bank=%0d",
                        cyc, bus.done, bus.err, bus.cur_bank, e.cyc, e.is_err, e.bank));
        end
      end
    end
  end

  // Reference: whole new coefficient set from the old one, plus the cycle each event is due.
  task automatic issue(input logic [AW-1:0] ord, input logic [31:0] kv);
    int c0;
    int i;
    bit legal;
    logic [31:0] a_old [16];
    logic [31:0] a_new;
    logic nb;
    i = int'(ord);
    legal = (i >= 1) && (i <= ORDER);
    @(negedge clk);
    c0 = cyc;
    bus.start = 1'b1;
    bus.order = ord;
    bus.k     = kv;
    if (legal) begin
      for (int a = 0; a < 16; a++) a_old[a] = ref_bank[ref_cur][a];
      nb = !ref_cur;
      for (int j = 1; j < i; j++) begin
        a_new = a_old[j] + qmul(kv, a_old[i-j]);
        q_mul.push_back('{c0 + j + 1, ref_cur, kv, a_old[i-j]});
        q_wr.push_back('{c0 + j + MUL_LAT + 1, AW'(j), nb, 1'b1, a_new});
        ref_bank[nb][j] = a_new;
      end
      q_wr.push_back('{(i > 1) ? c0 + i + MUL_LAT + 1 : c0 + 1, ord, nb, 1'b0, kv});
      ref_bank[nb][i] = kv;
      ref_cur = nb;
      q_ev.push_back('{(i > 1) ? c0 + i + MUL_LAT + 2 : c0 + 2, 1'b0, nb});
    end else begin
      q_ev.push_back('{c0 + 1, 1'b1, ref_cur});
    end
    @(negedge clk);
    bus.start = 1'b0;
    chk("busy", bus.busy == legal,
        $sformatf("order %0d busy=%0d, required %0d", i, bus.busy, legal));
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((q_wr.size() + q_mul.size() + q_ev.size()) != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("completion", n < 200,
        $sformatf("%0d cycles waited with %0d/%0d/%0d events outstanding, required under 200",
                  n, q_wr.size(), q_mul.size(), q_ev.size()));
    q_wr.delete(); q_mul.delete(); q_ev.delete();
    @(negedge clk);
  endtask

  task automatic chk_ram();
    int bad;
    bad = -1;
    for (int a = ORDER; a >= 1; a--)
      if (ram[ref_cur][a] != ref_bank[ref_cur][a]) bad = a;
    chk("ram_set", bad < 0,
        $sformatf("bank %0d first differing addr %0d: %h, required %h", ref_cur, bad,
                  (bad < 0) ? 32'h0 : ram[ref_cur][bad], (bad < 0) ? 32'h0 : ref_bank[ref_cur][bad]));
  endtask

  initial begin
    logic [31:0] saved [2][16];
    bus.start = 1'b0;
    bus.order = '0;
    bus.k     = '0;
    for (int b = 0; b < 2; b++)
      for (int a = 0; a < 16; a++) begin
        init_words[b][a] = small_rand();
        ref_bank[b][a]   = init_words[b][a];
      end
    ref_cur = 1'b0;

    // Reset held for three cycles, then ten idle cycles with every control output low.
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    ram_load = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      chk("reset_idle",
          {bus.busy, bus.done, bus.err, bus.mul_en, bus.wr_en, bus.out_sel, bus.cur_bank, bus.rd_bank,
           bus.rd_addr_a, bus.rd_addr_b, bus.wr_addr, bus.dp_a, bus.dp_k, bus.mul_x} == '0,
          $sformatf("cycle %0d busy=%0d wr_en=%0d mul_en=%0d cur_bank=%0d wr_addr=%0d dp_a=%h dp_k=%h, required all 0",
                    c, bus.busy, bus.wr_en, bus.mul_en, bus.cur_bank, bus.wr_addr, bus.dp_a, bus.dp_k));
    end

    issue(AW'(1), 32'h1000_0000);
    wait_idle(); chk_ram();
    issue(AW'(4), small_rand());
    wait_idle(); chk_ram();

    issue(AW'(0), small_rand());
    wait_idle();
    issue(AW'(ORDER + 1), small_rand());
    wait_idle();

    // start (legal and illegal) while streaming must be ignored; k changes must not leak in.
    issue(AW'(6), small_rand());
    @(negedge clk);
    bus.start = 1'b1; bus.order = '0;
    @(negedge clk);
    bus.order = AW'(3); bus.k = small_rand();
    @(negedge clk);
    bus.start = 1'b0;
    wait_idle(); chk_ram();

    // Asynchronous abort during the second streaming cycle.
    for (int b = 0; b < 2; b++)
      for (int a = 0; a < 16; a++) saved[b][a] = ref_bank[b][a];
    issue(AW'(5), small_rand());
    @(negedge clk);
    #2 rst = 1'b1;
    #1 chk("abort", !bus.wr_en && !bus.mul_en && !bus.busy && !bus.cur_bank,
           $sformatf("wr_en=%0d mul_en=%0d busy=%0d cur_bank=%0d, required all 0",
                     bus.wr_en, bus.mul_en, bus.busy, bus.cur_bank));
    q_wr.delete(); q_mul.delete(); q_ev.delete();
    for (int b = 0; b < 2; b++)
      for (int a = 0; a < 16; a++) ref_bank[b][a] = saved[b][a];
    ref_cur = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    issue(AW'(2), small_rand());
    wait_idle(); chk_ram();

    for (int i = 1; i <= ORDER; i++) begin
      issue(AW'(i), small_rand());
      wait_idle();
    end
    chk_ram();
`ifdef LEVINSON_CYCCNT_EN
    chk("last_cycles", bus.last_cycles == 16'(ORDER + MUL_LAT + 3),
        $sformatf("last_cycles=%0d, required %0d", bus.last_cycles, ORDER + MUL_LAT + 3));
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion before 200000");
    $fatal(1, "watchdog");
  end
endmodule
